// File: rtl/pe.sv
// SD4 MAC processing element: three signed 8-bit activations times three
// signed-digit radix-4 weights, shifted, added to the incoming psum, saturated.
module pe (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  exp_bias,
    input  logic [23:0] image_in,
    input  logic [35:0] weight,
    input  logic [15:0] psum,
    output logic [15:0] psum_out
);

    localparam int LANES   = 3;
    localparam int DIGITS  = 4;
    localparam int IMG_W   = 8;
    localparam int LANE_W  = 12;
    localparam int WGT_W   = 10;  // -340..+255
    localparam int PROD_W  = 18;  // |P| <= 43520
    localparam int SUM_W   = 20;
    localparam int ACC_W   = 21;
    localparam int PSUM_W  = 16;

    logic signed [WGT_W-1:0]  digit_term [LANES][DIGITS];
    logic signed [WGT_W-1:0]  lane_weight [LANES];
    logic signed [IMG_W-1:0]  lane_image [LANES];
    logic signed [PROD_W-1:0] lane_prod [LANES];

    logic signed [SUM_W-1:0]  dot_sum;
    logic signed [SUM_W-1:0]  scaled;
    logic signed [ACC_W-1:0]  acc;
    logic                     sat_hit;
    logic [PSUM_W-1:0]        psum_d;
    logic [PSUM_W-1:0]        psum_q;

    genvar gi, gk;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Each 3-bit digit is sign-extended then weighted by 4^k.
            for (gk = 0; gk < DIGITS; gk++) begin : g_digit
                assign digit_term[gi][gk] =
                    {{(WGT_W-3){weight[LANE_W*gi + 3*gk + 2]}},
                     weight[LANE_W*gi + 3*gk +: 3]} << (2*gk);
            end

            assign lane_weight[gi] = digit_term[gi][0] + digit_term[gi][1]
                                   + digit_term[gi][2] + digit_term[gi][3];
            assign lane_image[gi]  = image_in[IMG_W*gi +: IMG_W];
            assign lane_prod[gi]   = PROD_W'(lane_image[gi]) * PROD_W'(lane_weight[gi]);
        end
    endgenerate

    assign dot_sum = SUM_W'(lane_prod[0]) + SUM_W'(lane_prod[1]) + SUM_W'(lane_prod[2]);

    // Arithmetic shift floors; large shifts collapse to 0 or -1.
    assign scaled = dot_sum >>> exp_bias;

    assign acc = ACC_W'(scaled) + ACC_W'($signed(psum));

    // Out of 16-bit range whenever the bits above bit 15 disagree with the sign.
    assign sat_hit = (acc[ACC_W-1:PSUM_W-1] != {(ACC_W-PSUM_W+1){acc[ACC_W-1]}});

    always_comb begin
        psum_d = acc[PSUM_W-1:0];
        if (sat_hit) begin
            psum_d = acc[ACC_W-1] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psum_q <= '0;
        end else begin
            psum_q <= psum_d;
        end
    end

    assign psum_out = psum_q;

endmodule

// File: tb/tb_pe.sv
// Bench for pe: directed vector table, hand sequences, randomized back-to-back
// operands against an arithmetic reference model.
module tb_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  exp_bias;
    logic [23:0] image_in;
    logic [35:0] weight;
    logic [15:0] psum;
    logic [15:0] psum_out;

    int total  = 0;
    int passed = 0;

    pe dut (
        .clk      (clk),
        .rst      (rst),
        .exp_bias (exp_bias),
        .image_in (image_in),
        .weight   (weight),
        .psum     (psum),
        .psum_out (psum_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  exp_bias;
        logic [23:0] image_in;
        logic [35:0] weight;
        logic [15:0] psum;
        logic [15:0] expect_out;
    } vec_t;

    vec_t vecs [$];

    // Reference: decode digits as integers, floor-divide by 2^e, clamp.
    function automatic logic [15:0] model(input logic [4:0] e, input logic [23:0] img,
                                          input logic [35:0] w, input logic [15:0] ps);
        longint s = 0;
        longint div, t, r;
        for (int l = 0; l < 3; l++) begin
            longint a  = longint'($signed(img[8*l +: 8]));
            longint wv = 0;
            for (int k = 0; k < 4; k++) begin
                int code = int'(w[12*l + 3*k +: 3]);
                int dv   = (code >= 4) ? code - 8 : code;
                wv += longint'(dv) * (longint'(1) << (2*k));
            end
            s += a * wv;
        end
        div = longint'(1) << e;
        if (s >= 0) t = s / div;
        else        t = -((-s + div - 1) / div);
        r = t + longint'($signed(ps));
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) begin
            passed++;
            $display("pass %s psum_out=%h", name, got);
        end else begin
            $display("FAIL %s psum_out=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] e, input logic [23:0] img,
                         input logic [35:0] w, input logic [15:0] ps);
        rst      = r;
        exp_bias = e;
        image_in = img;
        weight   = w;
        psum     = ps;
    endtask

    task automatic step_check(input string name, input logic [15:0] exp);
        @(posedge clk);
        #1;
        check(name, psum_out, exp);
    endtask

    initial begin
        logic [4:0]  e;
        logic [23:0] img;
        logic [35:0] w;
        logic [15:0] ps;
        logic        r;

        vecs.push_back('{"reset0",    1'b1, 5'd3,  24'hABCDEF, 36'h123456789, 16'h7777, 16'h0000});
        vecs.push_back('{"reset1",    1'b1, 5'd0,  24'h7F7F7F, 36'h6DB6DB6DB, 16'h1234, 16'h0000});
        vecs.push_back('{"idle_zero", 1'b0, 5'd0,  24'h000000, 36'h000000000, 16'h0000, 16'h0000});
        vecs.push_back('{"basic_mac", 1'b0, 5'd0,  24'h010101, 36'h001001001, 16'h000F, 16'h0012});
        vecs.push_back('{"digit_shift",1'b0,5'd2,  24'h000064, 36'h000000008, 16'h0000, 16'h0064});
        vecs.push_back('{"neg_floor", 1'b0, 5'd1,  24'h0000FB, 36'h000000001, 16'h0000, 16'hFFFD});
        vecs.push_back('{"sat_pos",   1'b0, 5'd0,  24'h808080, 36'h924924924, 16'h7FFF, 16'h7FFF});
        vecs.push_back('{"sat_neg",   1'b0, 5'd0,  24'h7F7F7F, 36'h924924924, 16'h8000, 16'h8000});
        vecs.push_back('{"digit_neg1",1'b0, 5'd0,  24'h000003, 36'h000000007, 16'h0000, 16'hFFFD});
        vecs.push_back('{"digit_d3",  1'b0, 5'd0,  24'h000002, 36'h000000200, 16'h0000, 16'h0080});
        vecs.push_back('{"shift31_neg",1'b0,5'd31, 24'h0000FF, 36'h000000001, 16'h0000, 16'hFFFF});
        vecs.push_back('{"shift18_pos",1'b0,5'd18, 24'h7F7F7F, 36'h6DB6DB6DB, 16'h0005, 16'h0005});
        vecs.push_back('{"shift1_sat",1'b0, 5'd1,  24'h7F7F7F, 36'h6DB6DB6DB, 16'h0000, 16'h7FFF});
        vecs.push_back('{"shift17_neg",1'b0,5'd17, 24'h808080, 36'h6DB6DB6DB, 16'h0010, 16'h000F});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].exp_bias, vecs[i].image_in, vecs[i].weight, vecs[i].psum);
            step_check(vecs[i].name, vecs[i].expect_out);
        end

        // Mid-stream reset: operate, reset one cycle, resume.
        drive(1'b0, 5'd0, 24'h050505, 36'h001001001, 16'h0100);
        step_check("mid_pre", 16'h010F);
        drive(1'b1, 5'd0, 24'h050505, 36'h001001001, 16'h0100);
        step_check("mid_rst", 16'h0000);
        drive(1'b0, 5'd1, 24'h0000FB, 36'h000000001, 16'h0002);
        step_check("mid_post", 16'hFFFF);

        // Back-to-back randomized operands with occasional resets.
        for (int n = 0; n < 300; n++) begin
            r   = ($urandom_range(0, 19) == 0);
            e   = 5'($urandom_range(0, 31));
            img = 24'($urandom);
            w   = {4'($urandom), 32'($urandom)};
            ps  = 16'($urandom);
            if (n % 4 == 0) e = 5'($urandom_range(0, 3));
            drive(r, e, img, w, ps);
            step_check($sformatf("rand%0d", n), r ? 16'h0000 : model(e, img, w, ps));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
